// File: rtl/mc_controller_pkg.sv
// Shared types for the multicycle RISC-V controller: FSM states, opcodes,
// datapath select encodings and the per-state control word.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ERROR
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alucontrol_e;

  // Everything the FSM drives per state; pcwrite and the gated enables are
  // derived from this outside the state decode.
  typedef struct packed {
    srca_e   srca;
    srcb_e   srcb;
    result_e resultsrc;
    logic    adrsrc;
    logic    irwrite;
    logic    regwrite;
    logic    memwrite;
    logic    branch;
    logic    pcupdate;
    aluop_e  aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    srca:      SRCA_PC,
    srcb:      SRCB_RD2,
    resultsrc: RES_ALUOUT,
    adrsrc:    1'b0,
    irwrite:   1'b0,
    regwrite:  1'b0,
    memwrite:  1'b0,
    branch:    1'b0,
    pcupdate:  1'b0,
    aluop:     ALUOP_ADD
  };

  function automatic immsrc_e imm_decode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: return IMM_I;
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: turns the FSM's coarse aluop plus funct fields into the
// concrete ALU operation.
module mc_controller_aludec
  import mc_controller_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_e     aluop,
  output logic [2:0] alucontrol
);

  alucontrol_e alu_fn;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_fn = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_fn = ALU_ADD;
      ALUOP_SUB: alu_fn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can subtract; addi ignores instr[30].
          3'b000:  alu_fn = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_fn = ALU_SLT;
          3'b110:  alu_fn = ALU_OR;
          3'b111:  alu_fn = ALU_AND;
          default: alu_fn = ALU_ADD;
        endcase
      end
      default: alu_fn = ALU_ADD;
    endcase
  end

  assign alucontrol = alu_fn;

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: main FSM, immediate-select decode and the
// ALU decoder, driving the datapath selects and write enables.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e state;
  state_e state_next;
  ctrl_t  ctrl;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = ILLEGAL_TRAP ? S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_ERROR:    state_next = S_ERROR;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.adrsrc    = 1'b0;
        ctrl.irwrite   = 1'b1;
        ctrl.srca      = SRCA_PC;
        ctrl.srcb      = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.pcupdate  = 1'b1;
      end
      // Precompute PC+imm while the register file is read, for beq/jal.
      S_DECODE: begin
        ctrl.srca  = SRCA_OLDPC;
        ctrl.srcb  = SRCB_IMM;
        ctrl.aluop = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.srca  = SRCA_RD1;
        ctrl.srcb  = SRCB_IMM;
        ctrl.aluop = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.adrsrc    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.adrsrc    = 1'b1;
        ctrl.memwrite  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.srca  = SRCA_RD1;
        ctrl.srcb  = SRCB_RD2;
        ctrl.aluop = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.srca  = SRCA_RD1;
        ctrl.srcb  = SRCB_IMM;
        ctrl.aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regwrite  = 1'b1;
      end
      S_BEQ: begin
        ctrl.srca      = SRCA_RD1;
        ctrl.srcb      = SRCB_RD2;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      // Link value OldPC+4 goes to rd in the following ALUWB.
      S_JAL: begin
        ctrl.srca      = SRCA_OLDPC;
        ctrl.srcb      = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.pcupdate  = 1'b1;
      end
      S_ERROR: ctrl = CTRL_IDLE;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  mc_controller_aludec aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (ctrl.aluop),
    .alucontrol (alucontrol)
  );

  assign immsrc    = imm_decode(op);
  assign alusrca   = ctrl.srca;
  assign alusrcb   = ctrl.srcb;
  assign resultsrc = ctrl.resultsrc;
  assign adrsrc    = ctrl.adrsrc;

  // Reset forces FETCH, whose selects are the reset values; the enables are
  // gated by rst_n so FETCH's irwrite/pcupdate never pulse while held.
  assign irwrite  = rst_n & ctrl.irwrite;
  assign pcwrite  = rst_n & (ctrl.pcupdate | (ctrl.branch & zero));
  assign regwrite = rst_n & ctrl.regwrite;
  assign memwrite = rst_n & ctrl.memwrite;
  assign illegal  = rst_n & (state == S_ERROR);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, corner-case sequences and
// random instruction streams against an instruction-level model.
module tb_mc_controller;

  typedef struct packed {
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    bit         trap;
    int         cyc;
    ctl_t       exp;
  } vec_t;

  typedef enum {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
    ST_EXECR, ST_EXECI, ST_ALUWB, ST_BEQ, ST_JAL, ST_ERROR
  } step_e;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic [1:0] a_immsrc, a_alusrca, a_alusrcb, a_resultsrc;
  logic       a_adrsrc, a_irwrite, a_pcwrite, a_regwrite, a_memwrite, a_illegal;
  logic [2:0] a_alucontrol;
  logic [1:0] b_immsrc, b_alusrca, b_alusrcb, b_resultsrc;
  logic       b_adrsrc, b_irwrite, b_pcwrite, b_regwrite, b_memwrite, b_illegal;
  logic [2:0] b_alucontrol;

  ctl_t act_a, act_b;
  assign act_a = '{a_immsrc, a_alusrca, a_alusrcb, a_resultsrc, a_adrsrc, a_irwrite,
                   a_pcwrite, a_regwrite, a_memwrite, a_alucontrol, a_illegal};
  assign act_b = '{b_immsrc, b_alusrca, b_alusrcb, b_resultsrc, b_adrsrc, b_irwrite,
                   b_pcwrite, b_regwrite, b_memwrite, b_alucontrol, b_illegal};

  mc_controller #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(a_immsrc), .alusrca(a_alusrca), .alusrcb(a_alusrcb), .resultsrc(a_resultsrc),
    .adrsrc(a_adrsrc), .irwrite(a_irwrite), .pcwrite(a_pcwrite), .regwrite(a_regwrite),
    .memwrite(a_memwrite), .alucontrol(a_alucontrol), .illegal(a_illegal)
  );

  mc_controller #(.ILLEGAL_TRAP(1'b0)) u_nop (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(b_immsrc), .alusrca(b_alusrca), .alusrcb(b_alusrcb), .resultsrc(b_resultsrc),
    .adrsrc(b_adrsrc), .irwrite(b_irwrite), .pcwrite(b_pcwrite), .regwrite(b_regwrite),
    .memwrite(b_memwrite), .alucontrol(b_alucontrol), .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  vec_t  tv[$];
  step_e seq[$];

  function automatic ctl_t mk(logic [1:0] imm, logic [1:0] a, logic [1:0] b, logic [1:0] res,
                              logic adr, logic ir, logic pc, logic rw, logic mw,
                              logic [2:0] alu, logic ill);
    return '{imm, a, b, res, adr, ir, pc, rw, mw, alu, ill};
  endfunction

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (imm,a,b,res,adr,ir,pc,rw,mw,alu,ill)", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input bit trap, input int cyc, input ctl_t exp);
    vec_t v;
    v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.trap = trap; v.cyc = cyc; v.exp = exp;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BEQ || o == JAL;
  endfunction

  // Cycle-by-cycle phases of one instruction; length equals its latency.
  function automatic void build_seq(logic [6:0] o, bit trap);
    case (o)
      LW:      seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB};
      SW:      seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE};
      RT:      seq = '{ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB};
      IT:      seq = '{ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB};
      BEQ:     seq = '{ST_FETCH, ST_DECODE, ST_BEQ};
      JAL:     seq = '{ST_FETCH, ST_DECODE, ST_JAL, ST_ALUWB};
      default: seq = trap ? '{ST_FETCH, ST_DECODE, ST_ERROR, ST_ERROR, ST_ERROR}
                          : '{ST_FETCH, ST_DECODE};
    endcase
  endfunction

  function automatic ctl_t model(step_e s, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic [1:0] im;
    im = imm_of(o);
    case (s)
      ST_FETCH:    return mk(im, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      ST_DECODE:   return mk(im, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      ST_MEMADR:   return mk(im, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      ST_MEMREAD:  return mk(im, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      ST_MEMWB:    return mk(im, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      ST_MEMWRITE: return mk(im, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      ST_EXECR:    return mk(im, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu_of(o, f3, f7), 1'b0);
      ST_EXECI:    return mk(im, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu_of(o, f3, f7), 1'b0);
      ST_ALUWB:    return mk(im, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      ST_BEQ:      return mk(im, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, z,    1'b0, 1'b0, 3'b001, 1'b0);
      ST_JAL:      return mk(im, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      default:     return mk(im, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    endcase
  endfunction

  task automatic run_random(input bit trap, input int n_instr);
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    ctl_t       act;
    do_reset();
    for (int i = 0; i < n_instr; i++) begin
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BEQ;
        5: o = JAL;
        default: begin
          o = 7'($urandom);
          while (is_legal(o)) o = 7'($urandom);
        end
      endcase
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      build_seq(o, trap);
      for (int k = 0; k < seq.size(); k++) begin
        @(negedge clk);
        op = o; funct3 = f3; funct7b5 = f7; zero = 1'($urandom); rst_n = 1'b1;
        #1;
        act = trap ? act_a : act_b;
        check($sformatf("rand%0d op=%b step=%s", trap, o, seq[k].name()), act,
              model(seq[k], o, f3, f7, zero));
      end
      if (trap && !is_legal(o)) do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t fetch_lw, rst_lw, rst_sw;
    fetch_lw = mk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    rst_lw   = mk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    rst_sw   = mk(2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    //                imm    a      b      res   adr  ir   pc   rw   mw   alu     ill
    add("lw fetch",    LW, 3'd0, 0, 0, 1, 1, fetch_lw);
    add("lw decode",   LW, 3'd0, 0, 0, 1, 2, mk(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    add("lw memadr",   LW, 3'd0, 0, 0, 1, 3, mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    add("lw memread",  LW, 3'd0, 0, 0, 1, 4, mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0));
    add("lw memwb",    LW, 3'd0, 0, 0, 1, 5, mk(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 3'b000, 0));
    add("lw refetch",  LW, 3'd0, 0, 0, 1, 6, fetch_lw);
    add("sw memadr",   SW, 3'd2, 0, 0, 1, 3, mk(2'b01, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    add("sw memwrite", SW, 3'd2, 0, 0, 1, 4, mk(2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));
    add("sw refetch",  SW, 3'd2, 0, 0, 1, 5, mk(2'b01, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 3'b000, 0));
    add("r sub",       RT, 3'd0, 1, 0, 1, 3, mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0));
    add("r add",       RT, 3'd0, 0, 0, 1, 3, mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    add("r and",       RT, 3'd7, 1, 0, 1, 3, mk(2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0));
    add("r aluwb",     RT, 3'd6, 0, 0, 1, 4, mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));
    add("i addi f7",   IT, 3'd0, 1, 0, 1, 3, mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    add("i slti",      IT, 3'd2, 0, 0, 1, 3, mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b101, 0));
    add("i ori",       IT, 3'd6, 0, 0, 1, 3, mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b011, 0));
    add("beq decode",  BEQ, 3'd0, 0, 1, 1, 2, mk(2'b10, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    add("beq taken",   BEQ, 3'd0, 0, 1, 1, 3, mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 3'b001, 0));
    add("beq nottaken",BEQ, 3'd0, 0, 0, 1, 3, mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0));
    add("beq refetch", BEQ, 3'd0, 0, 0, 1, 4, mk(2'b10, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 3'b000, 0));
    add("jal jal",     JAL, 3'd0, 0, 0, 1, 3, mk(2'b11, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 3'b000, 0));
    add("jal aluwb",   JAL, 3'd0, 0, 0, 1, 4, mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));
    add("bad error",   BAD, 3'd0, 0, 0, 1, 3, mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
    add("bad sticks",  BAD, 3'd0, 0, 0, 1, 7, mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
    add("bad nop",     BAD, 3'd0, 0, 0, 0, 3, fetch_lw);
    add("bad nop dec", BAD, 3'd0, 0, 0, 0, 4, mk(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));

    // Reset state while rst_n is held low.
    rst_n = 1'b0; op = LW;
    #2;
    check("reset outputs", act_a, rst_lw);
    @(posedge clk); #1;
    check("reset held over edge", act_a, rst_lw);

    foreach (tv[i]) begin
      do_reset();
      @(negedge clk);
      op = tv[i].op; funct3 = tv[i].f3; funct7b5 = tv[i].f7; zero = tv[i].z; rst_n = 1'b1;
      repeat (tv[i].cyc - 1) @(negedge clk);
      #1;
      check(tv[i].name, tv[i].trap ? act_a : act_b, tv[i].exp);
    end

    // ERROR left only through an asynchronous reset, between clock edges.
    do_reset();
    @(negedge clk); op = BAD; zero = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("error before reset", act_a, mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
    #1 rst_n = 1'b0;
    #1 check("error async reset", act_a, rst_lw);
    @(negedge clk); op = LW; rst_n = 1'b1;
    #1 check("error restart fetch", act_a, fetch_lw);

    // Reset during MEMWRITE suppresses the store at once and across an edge.
    do_reset();
    @(negedge clk); op = SW; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("sw before abort", act_a, mk(2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));
    rst_n = 1'b0;
    #1 check("sw abort async", act_a, rst_sw);
    @(posedge clk); #1;
    check("sw abort held", act_a, rst_sw);

    // pcwrite follows zero combinationally inside the BEQ cycle.
    do_reset();
    @(negedge clk); op = BEQ; zero = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("beq zero low", act_a, mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0));
    zero = 1'b1;
    #1 check("beq zero rises", act_a, mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 3'b001, 0));

    run_random(1'b1, 80);
    run_random(1'b0, 80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
